fifo_rr_arbiter: RTL and testbench

//  Shares the push side of one sync_fifo among N_REQ producers. Producers use valid/ready.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_rr_arbiter_rr_pick.sv | 44 ++++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/fifo_rr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO push-side round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Burst counter width: large enough for MAX_BURST up to 255
  localparam int unsigned BURST_CW = 8;

  // Width of a producer index (grant_id, rotation pointer); at least 1 bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin pick: first requesting index strictly after i_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        i_req,
  input  logic [idx_w(N_REQ)-1:0] i_ptr,
  output logic                    o_any,
  output logic [idx_w(N_REQ)-1:0] o_idx
);

  localparam int unsigned IW = idx_w(N_REQ);

  logic [N_REQ-1:0] w_rot;
  logic [IW-1:0]    w_off;

  // Index that sits 'off' positions after the entry following base
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + 32'd1 + off;
    return IW'(s % N_REQ);
  endfunction

  // Rotate so the entry right after the pointer lands at bit 0
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_rot[k] = i_req[wrap(i_ptr, 32'(k))];
    end
  end

  // Priority-encode the rotated vector, lowest bit wins
  always_comb begin
    w_off = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign o_any = |i_req;
  assign o_idx = wrap(i_ptr, 32'(w_off));

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full / almost-full / empty / almost-empty flags.
module sync_fifo #(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned AF_TH = 1,
  parameter int unsigned AE_TH = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          a_full,
  output logic          a_empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = push & ~full;
  assign w_rd = pop & ~empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= din;
  end

  assign dout    = r_mem[r_rd];
  assign full    = (r_cnt == (AW+1)'(DEPTH));
  assign empty   = (r_cnt == '0);
  assign a_full  = (r_cnt >= (AW+1)'(DEPTH - AF_TH));
  assign a_empty = (r_cnt <= (AW+1)'(AE_TH));
  assign count   = r_cnt;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo push port among N_REQ valid/ready producers.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DW-1:0]     req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_a_full,
  output logic                    fifo_push,
  output logic [DW-1:0]           fifo_din,
  output logic [idx_w(N_REQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int unsigned          IW        = idx_w(N_REQ);
  localparam logic [BURST_CW-1:0]  LAST_BEAT = BURST_CW'(MAX_BURST - 1);
  // Pointer starts at the last index so producer 0 is first in line
  localparam logic [IW-1:0]        PTR_RST   = IW'(N_REQ - 1);

  state_t              r_state;
  logic                r_busy;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_ptr;
  logic [BURST_CW-1:0] r_cnt;
  logic                r_push;
  logic [DW-1:0]       r_din;

  logic                w_stall;
  logic                w_gnt_valid;
  logic                w_accept;
  logic [DW-1:0]       w_gnt_data;
  logic                w_pick_any;
  logic [IW-1:0]       w_pick_idx;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  // Stall also covers the push already registered but not yet seen in the FIFO count
  assign w_stall     = fifo_full | (r_push & fifo_a_full);
  assign w_gnt_valid = req_valid[r_grant];
  assign w_accept    = w_gnt_valid & req_ready[r_grant];

  // Only the granted producer may see ready, and only when the FIFO can take a beat
  always_comb begin
    req_ready = '0;
    if ((r_state == BURST) && !w_stall) req_ready[r_grant] = 1'b1;
  end

  // Select the granted producer's data slice
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_grant == IW'(i)) w_gnt_data = req_data[i*DW +: DW];
    end
  end

  // Arbitration FSM, burst counter, rotation pointer and registered push
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
      r_push  <= 1'b0;
      r_din   <= '0;
    end else begin
      r_push <= w_accept;
      if (w_accept) r_din <= w_gnt_data;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state <= BURST;
            r_busy  <= 1'b1;
            r_grant <= w_pick_idx;
            r_cnt   <= '0;
          end
        end
        BURST: begin
          if (w_accept) r_cnt <= r_cnt + BURST_CW'(1);
          // Release on a full burst or when the producer runs dry; never while stalled
          if ((w_accept && (r_cnt == LAST_BEAT)) || (!w_gnt_valid && !w_stall)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= r_grant;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_push = r_push;
  assign fifo_din  = r_din;
  assign grant_id  = r_grant;
  assign busy      = r_busy;

  // The registered push must never land on a full FIFO; at most one ready at a time
  a_no_overflow: assert property (@(posedge clk) disable iff (rstn) !(fifo_push && fifo_full));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (rstn) $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: fifo_rr_arbiter driving a 16-deep sync_fifo.
module tb_fifo_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full, fifo_a_full, fifo_push;
  logic [DW-1:0]    fifo_din, fifo_dout;
  logic [1:0]       grant_id;
  logic             busy;
  logic             fifo_pop, fifo_empty, fifo_a_empty;
  logic [4:0]       fifo_count;

  fifo_rr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_a_full(fifo_a_full), .fifo_push(fifo_push), .fifo_din(fifo_din),
    .grant_id(grant_id), .busy(busy)
  );

  sync_fifo #(4, 8, 1, 1) u_fifo (
    .clk(clk), .rstn(rstn), .push(fifo_push), .din(fifo_din), .pop(fifo_pop), .dout(fifo_dout),
    .full(fifo_full), .empty(fifo_empty), .a_full(fifo_a_full), .a_empty(fifo_a_empty), .count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ovf    = 0;
  int n_multi  = 0;
  int cyc      = 0;

  // Producer sources
  logic [7:0] src [N][32];
  int         head [N];
  int         len [N];
  logic       en [N];
  logic       acc [N];
  int         acc_cnt [N];
  logic       pop_en;
  logic       prev_busy;

  // Event logs
  int acc_dat[$], acc_cyc[$], push_dat[$], push_cyc[$], pop_dat[$], grant_log[$], idle_cyc[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic load(input int p, input int base, input int cnt);
    for (int k = 0; k < cnt; k++) src[p][k] = 8'(base + k);
    head[p] = 0;
    len[p]  = cnt;
    en[p]   = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; len[i] = 0; head[i] = 0; acc[i] = 1'b0; acc_cnt[i] = 0;
    end
    req_valid = '0;
    req_data  = '0;
    fifo_pop  = 1'b0;
    pop_en    = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    acc_dat.delete(); acc_cyc.delete(); push_dat.delete(); push_cyc.delete();
    pop_dat.delete(); grant_log.delete(); idle_cyc.delete();
    prev_busy = 1'b0;
  endtask

  // One cycle: retire last accepts, drive at negedge, sample 1 time unit later
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (head[i] < len[i]);
      req_data[i*DW +: DW] = (head[i] < len[i]) ? src[i][head[i]] : 8'h00;
    end
    fifo_pop = pop_en && !fifo_empty;
    if (fifo_pop) pop_dat.push_back(int'(fifo_dout));
    #1;
    for (int i = 0; i < N; i++) begin
      acc[i] = req_valid[i] && req_ready[i];
      if (acc[i]) begin
        acc_cnt[i]++;
        acc_dat.push_back(int'(src[i][head[i]]));
        acc_cyc.push_back(cyc);
      end
    end
    if (fifo_push) begin
      push_dat.push_back(int'(fifo_din));
      push_cyc.push_back(cyc);
    end
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    if (!busy) idle_cyc.push_back(cyc);
    prev_busy = busy;
    if (fifo_push && fifo_full) n_ovf++;
    if (!$onehot0(req_ready)) n_multi++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int exp_v, k_idx, first_a, last_a, idles;
    rstn = 1'b1;
    req_valid = '0; req_data = '0; fifo_pop = 1'b0; pop_en = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; len[i] = 0; head[i] = 0; acc[i] = 1'b0; acc_cnt[i] = 0;
    end

    // Reset values
    #22;
    chk("rst_push", int'(fifo_push), 0);
    chk("rst_din", int'(fifo_din), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_fifo_empty", int'(fifo_empty), 1);

    // 1: single producer, four contiguous beats
    do_reset();
    load(0, 'h10, 4);
    repeat (12) tick();
    chk("t1_push_cnt", push_dat.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t1_push_dat", (k < push_dat.size()) ? push_dat[k] : -1, 'h10 + k);
    chk("t1_latency", (push_cyc.size() > 0 && acc_cyc.size() > 0) ? push_cyc[0] - acc_cyc[0] : -1, 1);
    chk("t1_contig", (push_cyc.size() == 4) ? push_cyc[3] - push_cyc[0] : -1, 3);
    chk("t1_din_hold", int'(fifo_din), 'h13);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_grant_hold", int'(grant_id), 0);
    pop_en = 1'b1;
    repeat (8) tick();
    chk("t1_pop_cnt", pop_dat.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t1_pop_dat", (k < pop_dat.size()) ? pop_dat[k] : -1, 'h10 + k);

    // 2: all four valid, six beats each
    do_reset();
    pop_en = 1'b1;
    for (int p = 0; p < 4; p++) load(p, 'h80 + 16 * p, 6);
    repeat (60) tick();
    chk("t2_grant_cnt", grant_log.size(), 8);
    for (int g = 0; g < 8; g++)
      chk("t2_grant_order", (g < grant_log.size()) ? grant_log[g] : -1, g % 4);
    k_idx = 0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        for (int k = (r == 0 ? 0 : 4); k < (r == 0 ? 4 : 6); k++) begin
          exp_v = 'h80 + 16 * p + k;
          chk("t2_push_dat", (k_idx < push_dat.size()) ? push_dat[k_idx] : -1, exp_v);
          chk("t2_pop_dat", (k_idx < pop_dat.size()) ? pop_dat[k_idx] : -1, exp_v);
          k_idx++;
        end
    first_a = (acc_cyc.size() > 0) ? acc_cyc[0] : 0;
    last_a  = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size() - 1] : 0;
    chk("t2_span", last_a - first_a, 33);
    idles = 0;
    foreach (idle_cyc[j]) if (idle_cyc[j] > first_a && idle_cyc[j] < last_a) idles++;
    chk("t2_idle_cycles", idles, 7);

    // 3: backpressure with no pops
    do_reset();
    load(1, 'h20, 20);
    repeat (40) tick();
    chk("t3_push_cnt", push_dat.size(), 16);
    chk("t3_acc_cnt", acc_cnt[1], 16);
    chk("t3_full", int'(fifo_full), 1);
    chk("t3_ready", int'(req_ready), 0);
    chk("t3_busy_hold", int'(busy), 1);
    chk("t3_grant_hold", int'(grant_id), 1);
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    repeat (10) tick();
    chk("t3_acc_after_pop", acc_cnt[1], 17);
    chk("t3_push_after_pop", push_dat.size(), 17);
    chk("t3_pop_dat", (pop_dat.size() > 0) ? pop_dat[0] : -1, 'h20);
    chk("t3_full_again", int'(fifo_full), 1);

    // 4: early release by p2, then p3 with a fresh burst count
    do_reset();
    pop_en = 1'b1;
    load(2, 'h40, 2);
    load(3, 'h50, 5);
    repeat (30) tick();
    chk("t4_grant_cnt", grant_log.size(), 3);
    chk("t4_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    chk("t4_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    chk("t4_grant2", (grant_log.size() > 2) ? grant_log[2] : -1, 3);
    for (int k = 0; k < 7; k++)
      chk("t4_push_dat", (k < push_dat.size()) ? push_dat[k] : -1, (k < 2) ? 'h40 + k : 'h50 + k - 2);
    chk("t4_regrant_gap", (acc_cyc.size() == 7) ? acc_cyc[2] - acc_cyc[1] : -1, 3);
    chk("t4_p3_full_burst", (acc_cyc.size() == 7) ? acc_cyc[5] - acc_cyc[2] : -1, 3);
    chk("t4_rotation_gap", (acc_cyc.size() == 7) ? acc_cyc[6] - acc_cyc[5] : -1, 2);

    // 5: stall while p0 holds the grant near full
    do_reset();
    load(1, 'h60, 13);
    repeat (30) tick();
    chk("t5_prefill", push_dat.size(), 13);
    chk("t5_prefill_idle", int'(busy), 0);
    load(0, 'h70, 4);
    for (int g = 0; g < 20 && acc_cnt[0] < 3; g++) tick();
    chk("t5_p0_beats", acc_cnt[0], 3);
    tick();
    chk("t5_stall_push", int'(fifo_push), 1);
    chk("t5_stall_afull", int'(fifo_a_full), 1);
    chk("t5_stall_ready", int'(req_ready), 0);
    chk("t5_stall_busy", int'(busy), 1);
    chk("t5_stall_grant", int'(grant_id), 0);
    en[0] = 1'b0;
    load(3, 'h78, 2);
    repeat (6) tick();
    chk("t5_hold_busy", int'(busy), 1);
    chk("t5_hold_grant", int'(grant_id), 0);
    chk("t5_hold_ready", int'(req_ready), 0);
    chk("t5_hold_full", int'(fifo_full), 1);
    chk("t5_hold_p0", acc_cnt[0], 3);
    chk("t5_hold_pushes", push_dat.size(), 16);
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    repeat (6) tick();
    chk("t5_next_grant", (grant_log.size() > 0) ? grant_log[grant_log.size() - 1] : -1, 3);
    chk("t5_p3_beats", acc_cnt[3], 1);
    chk("t5_pushes_final", push_dat.size(), 17);

    // 6: reset in the middle of a p1 burst
    do_reset();
    pop_en = 1'b1;
    load(1, 'h90, 12);
    for (int g = 0; g < 20 && acc_cnt[1] < 6; g++) tick();
    chk("t6_mid_burst", acc_cnt[1], 6);
    #2;
    rstn = 1'b1;
    #1;
    chk("t6_rst_push", int'(fifo_push), 0);
    chk("t6_rst_din", int'(fifo_din), 0);
    chk("t6_rst_grant", int'(grant_id), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_ready", int'(req_ready), 0);
    do_reset();
    pop_en = 1'b1;
    load(0, 'hA0, 2);
    load(2, 'hB0, 2);
    repeat (12) tick();
    chk("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("t6_second_grant", (grant_log.size() > 1) ? grant_log[1] : -1, 2);
    chk("t6_first_push", (push_dat.size() > 0) ? push_dat[0] : -1, 'hA0);

    chk("no_overflow", n_ovf, 0);
    chk("ready_onehot0", n_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
